// File: rtl/struct.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int ADDR_LINE_REG = 5;
  localparam int D_SIZE        = 32;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    DRAIN = 2'b10,
    HALT  = 2'b11
  } hz_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_detect.sv
// Combinational hazard detect: RAW and load-use flags plus per-operand forward selects.
module hz_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                     valid,
  input  logic [ADDR_LINE_REG-1:0] id_rs,
  input  logic [ADDR_LINE_REG-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic [ADDR_LINE_REG-1:0] ex_dest,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic [ADDR_LINE_REG-1:0] mem_dest,
  input  logic                     mem_reg_write,
  output logic                     raw_hz,
  output logic                     lu_hz,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b
);

  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][ADDR_LINE_REG-1:0] src;
  logic [NUM_SRC-1:0]                    src_en;
  logic [NUM_SRC-1:0]                    ex_m;
  logic [NUM_SRC-1:0]                    mem_m;
  fwd_sel_t                              fwd_sel [NUM_SRC];

  assign src    = {id_rt, id_rs};
  assign src_en = {id_uses_rt, 1'b1};

  // r0 is hardwired zero, so it never forms a dependency
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign ex_m[i]    = src_en[i] && ex_reg_write && (ex_dest != '0) && (src[i] == ex_dest);
    assign mem_m[i]   = src_en[i] && mem_reg_write && (mem_dest != '0) && (src[i] == mem_dest);
    assign fwd_sel[i] = ex_m[i] ? FWD_EXMEM : (mem_m[i] ? FWD_MEMWB : FWD_REG);
  end

  assign raw_hz = valid && |(ex_m | mem_m);
  assign lu_hz  = valid && ex_mem_read && |ex_m;
  assign fwd_a  = fwd_sel[0];
  assign fwd_b  = fwd_sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush FSM with drain-to-halt and saturating stall counters.
// Define PIPE_FORWARDING_EN to stall only on load-use and drive the forward selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     opr_finished,
  input  logic [ADDR_LINE_REG-1:0] id_rs,
  input  logic [ADDR_LINE_REG-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic [ADDR_LINE_REG-1:0] ex_dest,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic [ADDR_LINE_REG-1:0] mem_dest,
  input  logic                     mem_reg_write,
  input  logic                     branch_taken,
  output logic                     stall,
  output logic                     flush,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     halted,
  output logic [CNT_W-1:0]         stall_wo_forewarding,
  output logic [CNT_W-1:0]         stall_w_forewarding
);

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam int PH_W = $clog2(max_int(FLUSH_CYCLES, DRAIN_CYCLES) + 1);

  hz_state_t       state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic            raw_hz, lu_hz, sel_hz, br_take;
  logic [1:0]      det_fwd_a, det_fwd_b;

  hz_detect u_hz_detect (
    .valid         (valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .raw_hz        (raw_hz),
    .lu_hz         (lu_hz),
    .fwd_a         (det_fwd_a),
    .fwd_b         (det_fwd_b)
  );

  assign sel_hz  = FWD_EN ? lu_hz : raw_hz;
  // end-of-program outranks a taken branch in the same cycle
  assign br_take = (state == RUN) && branch_taken && !opr_finished;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      RUN: begin
        if (opr_finished) begin
          state_nxt = DRAIN;
          phase_nxt = '0;
        end else if (branch_taken && FLUSH_CYCLES > 1) begin
          // the branch cycle itself is the first flush cycle
          state_nxt = FLUSH;
          phase_nxt = PH_W'(1);
        end
      end
      FLUSH: begin
        if (opr_finished) begin
          state_nxt = DRAIN;
          phase_nxt = '0;
        end else if (phase >= PH_W'(FLUSH_CYCLES - 1)) begin
          state_nxt = RUN;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      DRAIN: begin
        if (phase >= PH_W'(DRAIN_CYCLES - 1)) begin
          state_nxt = HALT;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      default: begin
        state_nxt = HALT;
        phase_nxt = '0;
      end
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    halted = 1'b0;
    fwd_a  = FWD_REG;
    fwd_b  = FWD_REG;
    case (state)
      RUN: begin
        flush = br_take;
        stall = !br_take && sel_hz;
        fwd_a = FWD_EN ? det_fwd_a : FWD_REG;
        fwd_b = FWD_EN ? det_fwd_b : FWD_REG;
      end
      FLUSH: flush = 1'b1;
      DRAIN: stall = 1'b1;
      default: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
    endcase
  end

  // counters track both hazard kinds regardless of build, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_wo_forewarding <= '0;
      stall_w_forewarding  <= '0;
    end else if (state == RUN && !br_take) begin
      if (raw_hz && stall_wo_forewarding != '1)
        stall_wo_forewarding <= stall_wo_forewarding + CNT_W'(1);
      if (lu_hz && stall_w_forewarding != '1)
        stall_w_forewarding <= stall_w_forewarding + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second CNT_W=4 instance covers counter saturation.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rst_s;
  logic        valid, opr_finished, id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_dest, mem_dest;
  logic        stall, flush, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] cnt_wo, cnt_w;
  logic        s_stall, s_flush, s_halted;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_wo, s_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_wo_forewarding(cnt_wo), .stall_w_forewarding(cnt_w)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(rst_s), .valid(valid), .opr_finished(opr_finished),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .branch_taken(branch_taken),
    .stall(s_stall), .flush(s_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted),
    .stall_wo_forewarding(s_wo), .stall_w_forewarding(s_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = 0; opr_finished = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_dest = 0; mem_reg_write = 0; branch_taken = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; rst_s = 0; clr();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_cnt_wo", cnt_wo, 0);
    chk("rst_cnt_w", cnt_w, 0);
    valid = 1; id_rs = 5; ex_dest = 5; ex_reg_write = 1; #1;
    chk("rst_comb_stall", stall, FWD ? 0 : 1);
    cyc();
    chk("rst_cnt_hold", cnt_wo, 0);
    clr(); reset = 1;

    // RAW: writer in EX then MEM
    valid = 1; id_rs = 5; ex_dest = 5; ex_reg_write = 1; #1;
    chk("raw_ex_stall", stall, FWD ? 0 : 1);
    chk("raw_ex_fwd_a", fwd_a, FWD ? 1 : 0);
    cyc();
    chk("raw_cnt1", cnt_wo, 1);
    ex_reg_write = 0; mem_dest = 5; mem_reg_write = 1; #1;
    chk("raw_mem_stall", stall, FWD ? 0 : 1);
    chk("raw_mem_fwd_a", fwd_a, FWD ? 2 : 0);
    cyc();
    mem_reg_write = 0; #1;
    chk("raw_wb_stall", stall, 0);
    chk("raw_cnt2", cnt_wo, 2);
    chk("raw_cnt_w0", cnt_w, 0);

    // match gating: r0, unused rt, reg_write, valid
    clr(); valid = 1; ex_dest = 0; id_rs = 0; ex_reg_write = 1; #1;
    chk("r0_stall", stall, 0);
    ex_dest = 7; id_rt = 7; id_uses_rt = 0; #1;
    chk("rt_unused_stall", stall, 0);
    id_uses_rt = 1; ex_reg_write = 0; #1;
    chk("no_rw_stall", stall, 0);
    ex_reg_write = 1; #1;
    chk("rt_used_stall", stall, FWD ? 0 : 1);
    chk("rt_used_fwd_b", fwd_b, FWD ? 1 : 0);
    valid = 0; #1;
    chk("invalid_stall", stall, 0);
    cyc();
    chk("gating_cnt", cnt_wo, 2);

    // load-use on rt
    clr(); valid = 1; id_rs = 1; id_rt = 8; id_uses_rt = 1;
    ex_dest = 8; ex_reg_write = 1; ex_mem_read = 1; #1;
    chk("lu_stall", stall, 1);
    cyc();
    chk("lu_cnt_w", cnt_w, 1);
    chk("lu_cnt_wo", cnt_wo, 3);
    ex_reg_write = 0; ex_mem_read = 0; mem_dest = 8; mem_reg_write = 1; #1;
    chk("lu_next_stall", stall, FWD ? 0 : 1);
    chk("lu_next_fwd_b", fwd_b, FWD ? 2 : 0);
    cyc();
    chk("lu_after_wo", cnt_wo, 4);
    chk("lu_after_w", cnt_w, 1);

    // EX/MEM priority over MEM/WB
    clr(); valid = 1; id_rs = 3; ex_dest = 3; mem_dest = 3; ex_reg_write = 1; mem_reg_write = 1; #1;
    chk("prio_fwd_a", fwd_a, FWD ? 1 : 0);
    chk("prio_stall", stall, FWD ? 0 : 1);
    cyc();

    // branch with a simultaneous RAW hazard
    clr(); valid = 1; id_rs = 5; ex_dest = 5; ex_reg_write = 1; branch_taken = 1; #1;
    chk("br0_flush", flush, 1);
    chk("br0_stall", stall, 0);
    cyc();
    branch_taken = 0; #1;
    chk("br1_flush", flush, 1);
    chk("br1_stall", stall, 0);
    chk("br1_fwd_a", fwd_a, 0);
    cyc();
    clr(); #1;
    chk("br2_flush", flush, 0);
    chk("br_cnt_wo", cnt_wo, 5);
    chk("br_cnt_w", cnt_w, 1);

    // drain to halt; opr_finished outranks branch
    opr_finished = 1; branch_taken = 1; #1;
    chk("fin_flush", flush, 0);
    cyc();
    clr();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_stall", stall, 1);
      chk("drain_halted", halted, 0);
      cyc();
    end
    chk("halt_halted", halted, 1);
    chk("halt_stall", stall, 1);
    cyc();
    branch_taken = 1; #1;
    chk("halt_hold", halted, 1);
    chk("halt_flush", flush, 0);
    reset = 0; #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_cnt", cnt_wo, 0);
    branch_taken = 0;
    cyc();
    reset = 1;

    // reset mid-DRAIN
    valid = 1; id_rs = 5; ex_dest = 5; ex_reg_write = 1;
    cyc();
    clr();
    chk("pre_drain_cnt", cnt_wo, 1);
    opr_finished = 1;
    cyc();
    opr_finished = 0;
    cyc(); cyc();
    #1;
    chk("mid_drain_stall", stall, 1);
    reset = 0; #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_cnt", cnt_wo, 0);
    cyc();
    reset = 1;
    cyc();
    chk("post_rst_stall", stall, 0);
    chk("post_rst_halted", halted, 0);

    // saturation on the narrow instance
    reset = 0;
    valid = 1; id_rs = 5; ex_dest = 5; ex_reg_write = 1; ex_mem_read = 1; rst_s = 1;
    repeat (3) cyc();
    chk("sat3_wo", s_wo, 3);
    chk("sat3_w", s_w, 3);
    chk("sat_stall", s_stall, 1);
    chk("sat_flush", s_flush, 0);
    chk("sat_halted", s_halted, 0);
    chk("sat_fwd_a", s_fwd_a, FWD ? 1 : 0);
    chk("sat_fwd_b", s_fwd_b, 0);
    repeat (11) cyc();
    chk("sat14_wo", s_wo, 4'hE);
    cyc();
    chk("sat15_wo", s_wo, 4'hF);
    repeat (5) cyc();
    chk("sat20_wo", s_wo, 4'hF);
    chk("sat20_w", s_w, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of both stall counters.
REQ-002 Parameter FLUSH_CYCLES, default 2, bubble cycles injected after a taken branch.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles allowed to empty the pipe after opr_finished.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, pipeline clock.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Ports valid and opr_finished, input, 1 each: valid means an instruction is in ID; opr_finished requests end of program.
REQ-008 Ports id_rs and id_rt, input, 5 each, source registers of the ID instruction; id_uses_rt, input, 1, means rt is a true source.
REQ-009 Ports ex_dest, ex_reg_write and ex_mem_read, inputs of 5, 1 and 1 bits, describe the EX-stage writer.
REQ-010 Ports mem_dest and mem_reg_write, inputs of 5 and 1 bits, describe the MEM-stage writer.
REQ-011 Port branch_taken, input, 1, branch resolved taken in EX.
REQ-012 Port stall, output, 1: hold PC and IF/ID, and inject a bubble into EX.
REQ-013 Port flush, output, 1: squash IF/ID contents.
REQ-014 Ports fwd_a and fwd_b, output, 2 each, operand source: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
REQ-015 Port halted, output, 1, pipeline stopped.
REQ-016 Ports stall_wo_forewarding and stall_w_forewarding, output, CNT_W each, stall cycle counters.

Function
REQ-017 FSM states SHALL be RUN, FLUSH, DRAIN and HALT.
REQ-018 Register 0 never matches a destination, and no match is raised unless the writer's reg_write is 1.
REQ-019 The raw hazard (raw_hz) SHALL be 1 when valid=1 and id_rs matches ex_dest or mem_dest, or id_uses_rt=1 and id_rt matches ex_dest or mem_dest.
  - WB-stage writes resolve through the register file write-before-read and are not hazards.
REQ-020 The load-use hazard (lu_hz) SHALL be 1 when valid=1, ex_mem_read=1 and id_rs or id_rt (rt gated by id_uses_rt) matches ex_dest.
REQ-021 In RUN, stall SHALL be a combinational function of the selected hazard with zero-cycle latency.
  - Selected hazard is lu_hz when forwarding is compiled in, raw_hz otherwise (see REQ-028/029).
REQ-022 RUN to FLUSH on branch_taken=1.
  - Branch has priority over hazard: flush=1 for FLUSH_CYCLES consecutive cycles starting that cycle.
  - stall=0 and neither counter increments during those cycles.
  - Return to RUN afterwards.
REQ-023 RUN or FLUSH to DRAIN on opr_finished=1.
  - opr_finished outranks branch_taken.
  - In DRAIN, stall=1 for DRAIN_CYCLES cycles, then HALT.
REQ-024 In HALT, stall=1 and halted=1; the block leaves HALT only on reset.
REQ-025 Outside RUN, fwd_a and fwd_b SHALL read 00.
REQ-026 stall_wo_forewarding increments each RUN cycle raw_hz=1, and stall_w_forewarding increments each RUN cycle lu_hz=1.
  - Both counters are independent of configuration.
  - Both saturate at all-ones with no wrap.

Reset
REQ-027 On reset=0, asynchronously:
  - state=RUN;
  - stall=0 and flush=0 in RUN (the combinational hazard path still drives stall if a hazard is presented while reset is low);
  - fwd_a=fwd_b=00;
  - halted=0;
  - both counters=0;
  - FLUSH and DRAIN cycle counters=0.
  - Reset mid-FLUSH or mid-DRAIN aborts the sequence immediately.

Configuration
REQ-028 With macro PIPE_FORWARDING_EN defined:
  - stall follows lu_hz, giving one bubble per load-use.
  - fwd_a and fwd_b are driven: EX/MEM match (01) has priority over MEM/WB match (10) for the same register.
REQ-029 Without PIPE_FORWARDING_EN:
  - stall follows raw_hz until the writer leaves MEM.
  - fwd_a and fwd_b are tied to 00.

Structure
REQ-030 The shared package (struct.sv) SHALL hold:
  - ADDR_LINE_REG and D_SIZE;
  - the fwd_sel_t enum (FWD_REG, FWD_EXMEM, FWD_MEMWB);
  - the hz_state_t enum (RUN, FLUSH, DRAIN, HALT).
REQ-031 One sub-module, hz_detect, SHALL be purely combinational and produce raw_hz, lu_hz and the forward selects; the FSM and counters SHALL live in pipe_hazard_ctrl.

Verification
REQ-032 Stimulus: ex_dest=5, ex_reg_write=1, id_rs=5, valid=1, no forwarding -> stall=1 for 2 cycles (EX then MEM); stall_wo_forewarding=2.
REQ-033 Stimulus: PIPE_FORWARDING_EN defined, ex_mem_read=1, ex_dest=8, id_rt=8, id_uses_rt=1 -> stall=1 for exactly 1 cycle, stall_w_forewarding=1; next cycle fwd_b=10.
REQ-034 Stimulus: PIPE_FORWARDING_EN defined, ex_dest=mem_dest=3, both reg_write=1, id_rs=3 -> fwd_a=01, stall=0.
REQ-035 Stimulus: branch_taken=1 in the same cycle as raw_hz=1 -> flush=1 for 2 cycles, stall=0, counters unchanged.
REQ-036 Stimulus: opr_finished pulse -> stall=1 for 4 cycles, then halted=1; reset=0 asserted mid-DRAIN -> halted=0, counters=0 immediately.
REQ-037 Stimulus: counter preset near all-ones with a hazard held -> counter saturates at 0xFFFFFFFF and does not wrap.
